// File: rtl/sell_machine_pkg.sv
// Shared types and constants for the $2.50 vending controller.
// Credit is tracked in half-dollar units.
package sell_machine_pkg;

   typedef enum logic [2:0] {
      S0  = 3'd0,
      S05 = 3'd1,
      S10 = 3'd2,
      S15 = 3'd3,
      S20 = 3'd4
   } state_t;

   localparam logic [2:0] HALF   = 3'd1;
   localparam logic [2:0] DOLLAR = 3'd2;
   localparam logic [2:0] PRICE  = 3'd5;

endpackage

// File: rtl/sell_machine_if.sv
// Coin-acceptor strobes in, dispenser/change/cashbox pulses out.
// The master is the front end; the slave is the controller.
interface sell_machine_if;
   import sell_machine_pkg::*;

   logic one_dollar;
   logic half_dollar;
   logic collect;
   logic half_out;
   logic dispense;

   modport master (
      output one_dollar,
      output half_dollar,
      input  collect,
      input  half_out,
      input  dispense
   );

   modport slave (
      input  one_dollar,
      input  half_dollar,
      output collect,
      output half_out,
      output dispense
   );

endinterface

// File: rtl/sell_machine.sv
// Vending controller: accumulates half-dollar credit, dispenses at 5 units,
// and returns one half-dollar when a dollar takes the credit to 6 units.
module sell_machine
   import sell_machine_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   sell_machine_if.slave bus
);

   state_t     state_reg;
   state_t     state_next;
   logic       collect_reg;
   logic       collect_next;
   logic       half_out_reg;
   logic       half_out_next;
   logic       dispense_reg;
   logic       dispense_next;
   logic [2:0] coin_value;
   logic [2:0] new_credit;

   always_comb begin
      coin_value    = 3'd0;
      state_next    = state_reg;
      collect_next  = 1'b0;
      half_out_next = 1'b0;
      dispense_next = 1'b0;

      // A dollar strobe wins when both strobes arrive together.
      if (bus.one_dollar) begin
         coin_value = DOLLAR;
      end else if (bus.half_dollar) begin
         coin_value = HALF;
      end

      new_credit = state_reg + coin_value;

      if (new_credit < PRICE) begin
         state_next = state_t'(new_credit);
      end else begin
         state_next    = S0;
         collect_next  = 1'b1;
         dispense_next = 1'b1;
         half_out_next = (new_credit > PRICE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S0;
         collect_reg  <= 1'b0;
         half_out_reg <= 1'b0;
         dispense_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         collect_reg  <= collect_next;
         half_out_reg <= half_out_next;
         dispense_reg <= dispense_next;
      end
   end

   assign bus.collect  = collect_reg;
   assign bus.half_out = half_out_reg;
   assign bus.dispense = dispense_reg;

endmodule

// File: tb/tb_sell_machine.sv
// Directed vector bench for sell_machine: one table row per clock edge,
// plus a held-strobe sequence checking pulse width and count.
module tb_sell_machine;
   import sell_machine_pkg::*;

   typedef struct {
      logic       rst;
      logic       od;
      logic       hd;
      int         exp_state;
      logic       exp_collect;
      logic       exp_half;
      logic       exp_disp;
   } vec_t;

   logic clk;
   logic reset;
   sell_machine_if bus ();

   sell_machine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t vecs[$];
   int   n_checks;
   int   n_pass;

   function automatic void add(input logic r, input logic od, input logic hd,
                               input int st, input logic c, input logic h,
                               input logic d);
      vec_t v;
      v.rst = r; v.od = od; v.hd = hd;
      v.exp_state = st; v.exp_collect = c; v.exp_half = h; v.exp_disp = d;
      vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input int idx, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic od, input logic hd);
      reset = r;
      bus.one_dollar  = od;
      bus.half_dollar = hd;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input int idx, input int st, input logic c,
                            input logic h, input logic d);
      check("state",    idx, int'(dut.state_reg), st);
      check("collect",  idx, int'(bus.collect),   int'(c));
      check("half_out", idx, int'(bus.half_out),  int'(h));
      check("dispense", idx, int'(bus.dispense),  int'(d));
      $display("step %0d: state=%0d collect=%0b half_out=%0b dispense=%0b",
               idx, dut.state_reg, bus.collect, bus.half_out, bus.dispense);
   endtask

   int disp_count;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      bus.one_dollar  = 1'b0;
      bus.half_dollar = 1'b0;

      // Reset held five edges, then release.
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      // Three dollars, two idle cycles apart: sale with change.
      add(0, 1, 0, 2, 0, 0, 0);
      add(0, 0, 0, 2, 0, 0, 0);
      add(0, 0, 0, 2, 0, 0, 0);
      add(0, 1, 0, 4, 0, 0, 0);
      add(0, 0, 0, 4, 0, 0, 0);
      add(0, 0, 0, 4, 0, 0, 0);
      add(0, 1, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      // Five halves: exact price, no change.
      add(0, 0, 1, 1, 0, 0, 0);
      add(0, 0, 1, 2, 0, 0, 0);
      add(0, 0, 1, 3, 0, 0, 0);
      add(0, 0, 1, 4, 0, 0, 0);
      add(0, 0, 1, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      // half, dollar, dollar.
      add(0, 0, 1, 1, 0, 0, 0);
      add(0, 1, 0, 3, 0, 0, 0);
      add(0, 1, 0, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      // Both strobes from S0 count as a dollar only.
      add(0, 1, 1, 2, 0, 0, 0);
      add(0, 0, 0, 2, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0) ;
      vecs.delete(vecs.size() - 1);
      add(0, 1, 0, 4, 0, 0, 0);
      add(0, 1, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      // From S15 both strobes reach exactly 5: no change.
      add(0, 0, 1, 1, 0, 0, 0);
      add(0, 0, 1, 2, 0, 0, 0);
      add(0, 0, 1, 3, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      // Reset at S20 together with a dollar: credit forfeited, nothing out.
      add(0, 1, 0, 2, 0, 0, 0);
      add(0, 1, 0, 4, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 2, 0, 0, 0);
      add(0, 1, 0, 4, 0, 0, 0);
      add(0, 1, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].od, vecs[i].hd);
         check_all(i, vecs[i].exp_state, vecs[i].exp_collect,
                   vecs[i].exp_half, vecs[i].exp_disp);
      end

      // Dollar strobe held for four edges counts as four coins:
      // 2, 4, sale with change, then 2 again; exactly one dispense pulse.
      disp_count = 0;
      step(0, 1, 0);
      check_all(100, 2, 0, 0, 0);
      disp_count += int'(bus.dispense);
      step(0, 1, 0);
      check_all(101, 4, 0, 0, 0);
      disp_count += int'(bus.dispense);
      step(0, 1, 0);
      check_all(102, 0, 1, 1, 1);
      disp_count += int'(bus.dispense);
      step(0, 1, 0);
      check_all(103, 2, 0, 0, 0);
      disp_count += int'(bus.dispense);
      check("held_dispense_count", 104, disp_count, 1);

      // Back-to-back sales: second sale completes three edges after the first.
      step(0, 1, 0);
      check_all(110, 4, 0, 0, 0);
      step(0, 1, 0);
      check_all(111, 0, 1, 1, 1);
      step(0, 1, 0);
      check_all(112, 2, 0, 0, 0);
      step(0, 1, 0);
      check_all(113, 4, 0, 0, 0);
      step(0, 0, 1);
      check_all(114, 0, 1, 0, 1);
      step(0, 0, 0);
      check_all(115, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
